mem_burst_master: RTL
=====================

// Module: mem_burst_master
// PURPOSE
//  Initiator side of the single-port data-memory interface (WE/Addr/Data in, SPO async out).
//  Accepts burst commands over a valid/ready handshake and drives the memory port.
//  Supported bursts: read-out, constant fill, incrementing-ramp fill.
//  Sits between CPU-side control/test logic and the data memory; sole owner of the memory port while busy.
// PARAMETERS
//  AW  6   memory address width (depth 2**AW words); also burst-length field width
//  DW  32  data word width
// PORTS
//  Clk        in   1   system clock; all state updates on rising edge
//  Rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command offered
//  cmd_ready  out  1   command accepted when cmd_valid && cmd_ready at a rising edge
//  cmd_op     in   2   00 READ, 01 FILL, 10 RAMP, 11 reserved
//  cmd_addr   in   AW  start word address
//  cmd_len    in   AW  burst length; 0 means 2**AW words
//  cmd_wdata  in   DW  FILL value / RAMP start value
//  rsp_valid  out  1   read beat available on rsp_data
//  rsp_ready  in   1   consumer takes beat when rsp_valid && rsp_ready
//  rsp_data   out  DW  read beat
//  done       out  1   one-cycle pulse at burst completion
//  err        out  1   one-cycle pulse, with done, for reserved op
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_data   out  DW  memory write data
//  mem_spo    in   DW  memory async read data (valid in the same cycle as mem_addr)
// BEHAVIOUR
//  Reset: state IDLE; ptr, cnt, val, rsp_data, mem_addr, mem_data = 0; rsp_valid, done, err, mem_we = 0; cmd_ready = 1.
//  Reset is checked before everything else. Reset mid-burst aborts immediately; words already written stay written.
//  FSM states: IDLE, RD, WR.
//  cmd_ready = (state==IDLE) && !rsp_valid.
//  On command acceptance: ptr<=cmd_addr; cnt<=cmd_len (0 loads 2**AW, held in an AW+1-bit counter); val<=cmd_wdata.
//    Next state: RD for op 00; WR for ops 01/10.
//    Op 11: stay IDLE; pulse done and err next cycle; no memory access.
//  mem_addr = ptr; mem_data = val; mem_we = (state==WR). All three decode from registers only, no comb path from cmd_*.
//  WR: one word written per cycle.
//    Each edge: ptr<=ptr+1 (mod 2**AW); cnt<=cnt-1; val<=val+1 (RAMP, DW-bit wrap) or unchanged (FILL).
//    On the edge where cnt==1: go IDLE; done pulses the following cycle.
//  RD: a beat is captured when !rsp_valid || rsp_ready.
//    Capture: rsp_data<=mem_spo; rsp_valid<=1; ptr++; cnt--.
//    Otherwise ptr, cnt and rsp_data hold, so no beat is skipped or duplicated.
//    rsp_valid clears on handoff when no new capture occurs.
//    Latency: accept at edge k gives first rsp_valid after edge k+1; throughput 1 beat/cycle under continuous rsp_ready.
//    On the capture where cnt==1: go IDLE; done pulses the next cycle (concurrent with the last rsp_valid).
//    The next command is blocked until the last beat is taken.
//  Address wrap: ptr 2**AW-1 -> 0 silently; a length-0 burst touches every word exactly once.
//  cmd_* inputs are ignored while cmd_ready==0.
// STRUCTURE
//  Package mem_master_pkg holds:
//    op encodings OP_READ/OP_FILL/OP_RAMP/OP_RSVD;
//    state enum {S_IDLE, S_RD, S_WR};
//    default AW/DW constants.
//  Single flat module, no sub-module. Response register and FSM are both small.
//  Bench instantiates the existing data memory as the responder on mem_* (AW=6, DW=32).
// TESTING
//  1 Reset: hold Rst 2 cycles -> all outputs 0 except cmd_ready=1; mem_we never high.
//  2 FILL addr=62 len=4 wdata=0xDEADBEEF -> mem_we high 4 cycles at addr 62,63,0,1; done 1 cycle; READ 62 len 4 returns 4x 0xDEADBEEF.
//  3 RAMP addr=0 len=0 wdata=0x00000100 -> 64 write cycles, mem[i]=0x100+i; READ len 0 returns 0x100..0x13F in order.
//  4 READ addr=10 len=3, rsp_ready low 5 cycles while beat 2 is pending -> rsp_data stable, beats mem[10],mem[11],mem[12] exactly once; cmd_ready low until last beat taken.
//  5 FILL addr=0 len=8 with Rst pulsed after 2 writes -> only mem[0],mem[1] changed; mem_we low the cycle after the reset edge; cmd_ready=1.
//  6 op=11 -> no mem_we; done and err high together for 1 cycle; cmd_ready stays 1.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared constants and types for the memory burst master.
package mem_master_pkg;

    localparam int unsigned DEF_AW = 6;
    localparam int unsigned DEF_DW = 32;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_FILL = 2'b01;
    localparam logic [1:0] OP_RAMP = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_e;

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port memory with an asynchronous read port.
// Runs read-out, constant-fill and incrementing-ramp bursts issued over a
// valid/ready command channel; read beats leave through a one-deep response register.
module mem_burst_master
    import mem_master_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          done,
    output logic          err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_spo
);

    localparam logic [AW-1:0] PtrOne = AW'(1);
    localparam logic [AW:0]   CntOne = (AW + 1)'(1);
    localparam logic [DW-1:0] ValOne = DW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] val_q, val_d;
    logic          ramp_q, ramp_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          capture;

    // Memory port and handshake outputs decode from registers only.
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
        mem_we    = (state_q == S_WR);
        mem_addr  = ptr_q;
        mem_data  = val_q;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        done      = done_q;
        err       = err_q;
    end

    // Next-state logic: command acceptance, write stepping and read beat capture.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        val_d       = val_q;
        ramp_d      = ramp_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        capture     = !rsp_valid_q || rsp_ready;

        // Handoff empties the response register unless a new capture refills it below.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == OP_RSVD) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        ptr_d   = cmd_addr;
                        // Zero length means the full 2**AW words: set the extra MSB.
                        cnt_d   = {(cmd_len == '0), cmd_len};
                        val_d   = cmd_wdata;
                        ramp_d  = (cmd_op == OP_RAMP);
                        state_d = (cmd_op == OP_READ) ? S_RD : S_WR;
                    end
                end
            end
            S_RD: begin
                if (capture) begin
                    rsp_data_d  = mem_spo;
                    rsp_valid_d = 1'b1;
                    ptr_d       = ptr_q + PtrOne;
                    cnt_d       = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WR: begin
                ptr_d = ptr_q + PtrOne;
                cnt_d = cnt_q - CntOne;
                if (ramp_q) begin
                    val_d = val_q + ValOne;
                end
                if (cnt_q == CntOne) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; reset aborts any burst in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            val_q       <= '0;
            ramp_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            ramp_q      <= ramp_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
